ifu_fetch: RTL and testbench

- Instruction-fetch stage of the NPC core; sits directly upstream of the decoder.
- Owns the PC, issues one-at-a-time word reads to instruction memory, and presents {instruction, pc} to the decoder over a valid/ready handshake.
- Accepts PC redirects from execute/branch logic and squashes in-flight or held fetches.

---
 rtl/ifu_fetch_pkg.sv | 20 ++
 rtl/ifu_pc_reg.sv | 43 ++++
 rtl/ifu_fetch.sv | 143 ++++++++++++++
 tb/tb_ifu_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the NPC instruction-fetch stage: FSM encoding,
// the NOP used for faulting fetches, and default widths/reset PC.
package ifu_fetch_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [31:0] NOP_INS          = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
  localparam int          INS_W_DEF        = 32;

  // Word fetches need the two low address bits clear.
  function automatic logic pc_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register for the fetch stage. A redirect wins over the
// sequential +4 step; otherwise the PC holds. Also flags word misalignment.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_misaligned
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;

  // Select the next PC: redirect target, sequential step (wraps naturally), or hold.
  always_comb begin
    w_pc_next = r_pc;
    if (i_load) begin
      w_pc_next = i_load_pc;
    end else if (i_inc) begin
      w_pc_next = r_pc + ADDR_W'(4);
    end
  end

  // PC state, reloaded with the boot address on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc         = r_pc;
  assign o_misaligned = pc_misaligned(r_pc[1:0]);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: issues one word read at a time, holds the result
// for the decoder until it is consumed, and squashes work on a redirect.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                INS_W    = INS_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INS_W-1:0]  imem_resp_data,
  input  logic              imem_resp_err,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INS_W-1:0]  ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_fault,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [ADDR_W-1:0] w_pc;
  logic              w_misaligned;
  logic              w_pc_inc;
  logic              w_req_fire;

  logic              r_ins_valid;
  logic [INS_W-1:0]  r_ins_data;
  logic [ADDR_W-1:0] r_ins_pc;
  logic              r_ins_fault;

  // Every redirect loads the PC regardless of state; a consumed instruction steps it.
  assign w_pc_inc = (r_state == ST_HOLD) && ins_ready && !redirect_valid;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .i_load       (redirect_valid),
    .i_load_pc    (redirect_pc),
    .i_inc        (w_pc_inc),
    .o_pc         (w_pc),
    .o_misaligned (w_misaligned)
  );

  assign imem_req_valid = (r_state == ST_REQ) && !w_misaligned;
  assign imem_req_addr  = w_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Next-state logic; a redirect with a request already accepted must drain its orphan response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: w_state_next = ST_REQ;
      ST_REQ: begin
        if (redirect_valid) begin
          w_state_next = w_req_fire ? ST_DRAIN : ST_REQ;
        end else if (w_misaligned) begin
          w_state_next = ST_HOLD;
        end else if (w_req_fire) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          w_state_next = imem_resp_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_resp_valid) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || ins_ready) begin
          w_state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) begin
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Decoder-facing registers: loaded on a fault or good response, cleared when consumed or squashed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ins_valid <= 1'b0;
      r_ins_data  <= '0;
      r_ins_pc    <= '0;
      r_ins_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (!redirect_valid && w_misaligned) begin
            r_ins_valid <= 1'b1;
            r_ins_data  <= INS_W'(NOP_INS);
            r_ins_pc    <= w_pc;
            r_ins_fault <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!redirect_valid && imem_resp_valid) begin
            r_ins_valid <= 1'b1;
            r_ins_data  <= imem_resp_err ? INS_W'(NOP_INS) : imem_resp_data;
            r_ins_pc    <= w_pc;
            r_ins_fault <= imem_resp_err;
          end
        end
        ST_HOLD: begin
          if (redirect_valid || ins_ready) begin
            r_ins_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ins_valid = r_ins_valid;
  assign ins_data  = r_ins_data;
  assign ins_pc    = r_ins_pc;
  assign ins_fault = r_ins_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch, with a behavioural memory
// per DUT instance; a second instance boots near the top of the address space.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [63:0] ins_pc;
  logic        ins_fault;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  logic        wReqValid;
  logic        wReqReady;
  logic [63:0] wReqAddr;
  logic        wRespValid;
  logic [31:0] wRespData;
  logic        wRespErr;
  logic        wInsValid;
  logic        wInsReady;
  logic [31:0] wInsData;
  logic [63:0] wInsPc;
  logic        wInsFault;
  logic        wRedirValid;
  logic [63:0] wRedirPc;

  int          assertCount = 0;
  int          failCount   = 0;
  int          reqCount    = 0;
  int          respDelay   = 1;
  logic [63:0] lastReqAddr = '0;
  logic [63:0] errAddr     = 64'h8000_0010;

  logic        mPending = 1'b0;
  int          mCnt     = 0;
  logic [63:0] mAddr    = '0;
  logic        wPending = 1'b0;
  logic [63:0] wAddr    = '0;

  always #5 clk = ~clk;

  ifu_fetch u_dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .ins_valid       (ins_valid),
    .ins_ready       (ins_ready),
    .ins_data        (ins_data),
    .ins_pc          (ins_pc),
    .ins_fault       (ins_fault),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  ifu_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dutWrap (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (wReqValid),
    .imem_req_ready  (wReqReady),
    .imem_req_addr   (wReqAddr),
    .imem_resp_valid (wRespValid),
    .imem_resp_data  (wRespData),
    .imem_resp_err   (wRespErr),
    .ins_valid       (wInsValid),
    .ins_ready       (wInsReady),
    .ins_data        (wInsData),
    .ins_pc          (wInsPc),
    .ins_fault       (wInsFault),
    .redirect_valid  (wRedirValid),
    .redirect_pc     (wRedirPc)
  );

  // Main memory model: accepts a request, answers respDelay cycles later with a
  // word derived from the address, flagging an error at errAddr.
  always @(negedge clk) begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    if (rst) begin
      mPending = 1'b0;
    end else begin
      if (mPending) begin
        if (mCnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = 32'hC0DE_0000 | {16'h0, mAddr[15:0]};
          imem_resp_err   = (mAddr == errAddr);
          mPending        = 1'b0;
        end else begin
          mCnt--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        mPending    = 1'b1;
        mCnt        = respDelay - 1;
        mAddr       = imem_req_addr;
        reqCount++;
        lastReqAddr = imem_req_addr;
      end
    end
  end

  // Memory model for the wrap instance: always ready, answers on the next cycle.
  always @(negedge clk) begin
    wRespValid = 1'b0;
    wRespData  = '0;
    wRespErr   = 1'b0;
    if (rst) begin
      wPending = 1'b0;
    end else begin
      if (wPending) begin
        wRespValid = 1'b1;
        wRespData  = 32'hC0DE_0000 | {16'h0, wAddr[15:0]};
        wPending   = 1'b0;
      end
      if (wReqValid && wReqReady) begin
        wPending = 1'b1;
        wAddr    = wReqAddr;
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] pc);
    redirect_valid = valid;
    redirect_pc    = pc;
  endtask

  task automatic waitMainValid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ins_valid && n < 20);
    if (!ins_valid) checkOutput({tag, " timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int base;
    int n;
    logic sawValid;

    imem_req_ready = 1'b1;
    ins_ready      = 1'b1;
    wReqReady      = 1'b1;
    wInsReady      = 1'b1;
    wRedirValid    = 1'b0;
    wRedirPc       = '0;
    applyStimulus(1'b0, '0);

    // Reset values
    @(negedge clk);
    checkOutput("rst ins_valid", {63'd0, ins_valid}, 64'd0);
    checkOutput("rst ins_data", {32'd0, ins_data}, 64'd0);
    checkOutput("rst ins_pc", ins_pc, 64'd0);
    checkOutput("rst ins_fault", {63'd0, ins_fault}, 64'd0);
    checkOutput("rst req_valid", {63'd0, imem_req_valid}, 64'd0);
    checkOutput("rst pc", imem_req_addr, 64'h8000_0000);
    rst = 1'b0;

    // Sequential fetch with zero-wait memory
    for (int i = 0; i < 3; i++) begin
      waitMainValid("seq");
      checkOutput("seq pc", ins_pc, 64'h8000_0000 + 64'(4 * i));
      checkOutput("seq data", {32'd0, ins_data}, {32'd0, 32'hC0DE_0000 + 32'(4 * i)});
      checkOutput("seq fault", {63'd0, ins_fault}, 64'd0);
    end
    checkOutput("seq req count", 64'(reqCount), 64'd3);

    // Decoder backpressure holds everything still
    ins_ready = 1'b0;
    respDelay = 3;
    base      = reqCount;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp valid", {63'd0, ins_valid}, 64'd1);
      checkOutput("bp pc", ins_pc, 64'h8000_0008);
      checkOutput("bp data", {32'd0, ins_data}, 64'hC0DE_0008);
      checkOutput("bp req_valid", {63'd0, imem_req_valid}, 64'd0);
      checkOutput("bp pc reg", imem_req_addr, 64'h8000_0008);
    end
    checkOutput("bp req count", 64'(reqCount), 64'(base));
    ins_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp next req_valid", {63'd0, imem_req_valid}, 64'd1);
    checkOutput("bp next addr", imem_req_addr, 64'h8000_000C);

    // Redirect in WAIT; the late response must be dropped
    @(negedge clk);
    applyStimulus(1'b1, 64'h8000_1000);
    base = reqCount;
    @(negedge clk);
    applyStimulus(1'b0, '0);
    respDelay = 1;
    sawValid  = 1'b0;
    n = 0;
    while (reqCount == base && n < 12) begin
      @(negedge clk);
      if (ins_valid) sawValid = 1'b1;
      n++;
    end
    checkOutput("drain no valid", {63'd0, sawValid}, 64'd0);
    checkOutput("drain next addr", lastReqAddr, 64'h8000_1000);
    waitMainValid("redir");
    checkOutput("redir pc", ins_pc, 64'h8000_1000);
    checkOutput("redir data", {32'd0, ins_data}, 64'hC0DE_1000);

    // Redirect coincident with a HOLD handshake
    applyStimulus(1'b1, 64'h8000_0200);
    @(negedge clk);
    applyStimulus(1'b0, '0);
    checkOutput("hold redir addr", imem_req_addr, 64'h8000_0200);
    checkOutput("hold redir req_valid", {63'd0, imem_req_valid}, 64'd1);
    waitMainValid("hold redir");
    checkOutput("hold redir pc", ins_pc, 64'h8000_0200);
    checkOutput("hold redir data", {32'd0, ins_data}, 64'hC0DE_0200);

    // Misaligned redirect target
    applyStimulus(1'b1, 64'h8000_0102);
    @(negedge clk);
    applyStimulus(1'b0, '0);
    base = reqCount;
    checkOutput("mis req_valid", {63'd0, imem_req_valid}, 64'd0);
    waitMainValid("mis");
    checkOutput("mis pc", ins_pc, 64'h8000_0102);
    checkOutput("mis data", {32'd0, ins_data}, 64'h0000_0013);
    checkOutput("mis fault", {63'd0, ins_fault}, 64'd1);
    checkOutput("mis req count", 64'(reqCount), 64'(base));

    // Memory access error
    applyStimulus(1'b1, 64'h8000_0010);
    @(negedge clk);
    applyStimulus(1'b0, '0);
    waitMainValid("err");
    checkOutput("err pc", ins_pc, 64'h8000_0010);
    checkOutput("err data", {32'd0, ins_data}, 64'h0000_0013);
    checkOutput("err fault", {63'd0, ins_fault}, 64'd1);

    // Asynchronous reset mid-operation
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst valid", {63'd0, ins_valid}, 64'd0);
    checkOutput("midrst ins_pc", ins_pc, 64'd0);
    checkOutput("midrst fault", {63'd0, ins_fault}, 64'd0);
    checkOutput("midrst pc", imem_req_addr, 64'h8000_0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // PC wraps past the top of the address space
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wInsValid && n < 20);
    checkOutput("wrap valid", {63'd0, wInsValid}, 64'd1);
    checkOutput("wrap pc", wInsPc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap data", {32'd0, wInsData}, 64'hC0DE_FFFC);
    @(negedge clk);
    checkOutput("wrap next req_valid", {63'd0, wReqValid}, 64'd1);
    checkOutput("wrap next addr", wReqAddr, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
